// File: rtl/rename_alias_table_3way.sv
// Three-wide rename stage: speculative/committed alias tables, intra-group
// bypass, all-or-nothing tag allocation and a one-deep valid/ready output register.
module rename_alias_table_3way #(
  parameter int ARCH_REGS    = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int FL_CNT_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          slot_valid_0, slot_valid_1, slot_valid_2,
  input  logic [$clog2(ARCH_REGS)-1:0]  rs1_0, rs1_1, rs1_2,
  input  logic [$clog2(ARCH_REGS)-1:0]  rs2_0, rs2_1, rs2_2,
  input  logic [$clog2(ARCH_REGS)-1:0]  rd_0, rd_1, rd_2,
  input  logic                          rd_write_0, rd_write_1, rd_write_2,
  output logic                          fl_read_en_0, fl_read_en_1, fl_read_en_2,
  input  logic [TAG_WIDTH-1:0]          fl_read_data_0, fl_read_data_1, fl_read_data_2,
  input  logic                          fl_read_valid_0, fl_read_valid_1, fl_read_valid_2,
  input  logic [FL_CNT_WIDTH-1:0]       fl_count,
  output logic                          fl_write_en_0, fl_write_en_1, fl_write_en_2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_slot_valid_0, out_slot_valid_1, out_slot_valid_2,
  output logic [TAG_WIDTH-1:0]          out_rs1_tag_0, out_rs1_tag_1, out_rs1_tag_2,
  output logic [TAG_WIDTH-1:0]          out_rs2_tag_0, out_rs2_tag_1, out_rs2_tag_2,
  output logic [TAG_WIDTH-1:0]          out_rd_tag_0, out_rd_tag_1, out_rd_tag_2,
  output logic [TAG_WIDTH-1:0]          out_old_tag_0, out_old_tag_1, out_old_tag_2,
  input  logic                          commit_en_0, commit_en_1, commit_en_2,
  input  logic [$clog2(ARCH_REGS)-1:0]  commit_rd_0, commit_rd_1, commit_rd_2,
  input  logic [TAG_WIDTH-1:0]          commit_tag_0, commit_tag_1, commit_tag_2,
  input  logic                          flush
);

  localparam int IDX_W = $clog2(ARCH_REGS);
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;

  logic [2:0] slot_v, rd_wr, need, rd_en, fl_rv, c_en;
  idx_t       rs1 [3], rs2 [3], rd [3], c_rd [3];
  tag_t       fl_data [3], c_tag [3];
  logic [1:0] num_need;
  logic       fire, out_valid_d;

  tag_t srat_q [ARCH_REGS], srat_d [ARCH_REGS];
  tag_t crat_q [ARCH_REGS], crat_d [ARCH_REGS];
  tag_t src1 [3], src2 [3], old_tag [3], new_tag [3];

  logic       out_valid_q;
  logic [2:0] out_slot_valid_q;
  tag_t       out_rs1_q [3], out_rs2_q [3], out_rd_q [3], out_old_q [3];

  assign slot_v  = {slot_valid_2, slot_valid_1, slot_valid_0};
  assign rd_wr   = {rd_write_2, rd_write_1, rd_write_0};
  assign fl_rv   = {fl_read_valid_2, fl_read_valid_1, fl_read_valid_0};
  assign c_en    = {commit_en_2, commit_en_1, commit_en_0};
  assign rs1     = '{rs1_0, rs1_1, rs1_2};
  assign rs2     = '{rs2_0, rs2_1, rs2_2};
  assign rd      = '{rd_0, rd_1, rd_2};
  assign c_rd    = '{commit_rd_0, commit_rd_1, commit_rd_2};
  assign fl_data = '{fl_read_data_0, fl_read_data_1, fl_read_data_2};
  assign c_tag   = '{commit_tag_0, commit_tag_1, commit_tag_2};

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    num_need = '0;
    for (int k = 0; k < 3; k++) begin
      need[k]  = slot_v[k] & rd_wr[k] & (rd[k] != '0);
      num_need = num_need + 2'(need[k]);
    end
  end

  assign in_ready = !flush && (!out_valid_q || out_ready)
                    && (fl_count >= FL_CNT_WIDTH'(num_need));
  assign fire     = rst_n & in_valid & in_ready;
  assign rd_en    = {3{fire}} & need;
  assign {fl_read_en_2, fl_read_en_1, fl_read_en_0} = rd_en;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      src1[k]    = (rs1[k] == '0) ? '0 : srat_q[rs1[k]];
      src2[k]    = (rs2[k] == '0) ? '0 : srat_q[rs2[k]];
      old_tag[k] = (rd[k]  == '0) ? '0 : srat_q[rd[k]];
      new_tag[k] = need[k] ? fl_data[k] : '0;
      // Ascending scan: the youngest earlier writer overrides older ones.
      for (int j = 0; j < k; j++) begin
        if (need[j] && rd[j] == rs1[k]) src1[k]    = fl_data[j];
        if (need[j] && rd[j] == rs2[k]) src2[k]    = fl_data[j];
        if (need[j] && rd[j] == rd[k])  old_tag[k] = fl_data[j];
      end
    end
  end

  always_comb begin
    {fl_write_en_2, fl_write_en_1, fl_write_en_0} = '0;
    crat_d = crat_q;
    for (int k = 0; k < 3; k++) begin
      if (c_en[k] && c_rd[k] != '0) crat_d[c_rd[k]] = c_tag[k];
    end
    fl_write_en_0 = rst_n & c_en[0] & (c_rd[0] != '0);
    fl_write_en_1 = rst_n & c_en[1] & (c_rd[1] != '0);
    fl_write_en_2 = rst_n & c_en[2] & (c_rd[2] != '0);

    srat_d = srat_q;
    if (flush) begin
      srat_d = crat_d;
    end else if (fire) begin
      for (int k = 0; k < 3; k++) begin
        if (need[k]) srat_d[rd[k]] = fl_data[k];
      end
    end

    out_valid_d = out_valid_q;
    if (fire)                    out_valid_d = 1'b1;
    else if (flush || out_ready) out_valid_d = 1'b0;
  end

  // NOTE: both alias tables must come out of reset as identity maps, so these
  // arrays are built from reset flops rather than an unreset memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        srat_q[i] <= TAG_WIDTH'(i);
        crat_q[i] <= TAG_WIDTH'(i);
      end
      out_valid_q      <= 1'b0;
      out_slot_valid_q <= '0;
      for (int k = 0; k < 3; k++) begin
        out_rs1_q[k] <= '0;
        out_rs2_q[k] <= '0;
        out_rd_q[k]  <= '0;
        out_old_q[k] <= '0;
      end
    end else begin
      srat_q      <= srat_d;
      crat_q      <= crat_d;
      out_valid_q <= out_valid_d;
      if (fire) begin
        out_slot_valid_q <= slot_v;
        out_rs1_q        <= src1;
        out_rs2_q        <= src2;
        out_rd_q         <= new_tag;
        out_old_q        <= old_tag;
      end
    end
  end

  // A granted read must always return a tag; the free list guarantees this.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        assert (!rd_en[k] || fl_rv[k]);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign {out_slot_valid_2, out_slot_valid_1, out_slot_valid_0} = out_slot_valid_q;
  assign out_rs1_tag_0 = out_rs1_q[0];
  assign out_rs1_tag_1 = out_rs1_q[1];
  assign out_rs1_tag_2 = out_rs1_q[2];
  assign out_rs2_tag_0 = out_rs2_q[0];
  assign out_rs2_tag_1 = out_rs2_q[1];
  assign out_rs2_tag_2 = out_rs2_q[2];
  assign out_rd_tag_0  = out_rd_q[0];
  assign out_rd_tag_1  = out_rd_q[1];
  assign out_rd_tag_2  = out_rd_q[2];
  assign out_old_tag_0 = out_old_q[0];
  assign out_old_tag_1 = out_old_q[1];
  assign out_old_tag_2 = out_old_q[2];

endmodule

// File: tb/tb_rename_alias_table_3way.sv
// Directed bench for rename_alias_table_3way with hand-computed expected tags.
module tb_rename_alias_table_3way;

  logic       clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic       slot_valid [3], rd_write [3], fl_rv [3], fl_ren [3], fl_wen [3];
  logic [4:0] rs1 [3], rs2 [3], rd [3], c_rd [3];
  logic [5:0] fl_data [3], c_tag [3], fl_count;
  logic       c_en [3], o_sv [3];
  logic [5:0] o_rs1 [3], o_rs2 [3], o_rd [3], o_old [3];

  int checks = 0;
  int errors = 0;

  rename_alias_table_3way dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .slot_valid_0(slot_valid[0]), .slot_valid_1(slot_valid[1]), .slot_valid_2(slot_valid[2]),
    .rs1_0(rs1[0]), .rs1_1(rs1[1]), .rs1_2(rs1[2]),
    .rs2_0(rs2[0]), .rs2_1(rs2[1]), .rs2_2(rs2[2]),
    .rd_0(rd[0]), .rd_1(rd[1]), .rd_2(rd[2]),
    .rd_write_0(rd_write[0]), .rd_write_1(rd_write[1]), .rd_write_2(rd_write[2]),
    .fl_read_en_0(fl_ren[0]), .fl_read_en_1(fl_ren[1]), .fl_read_en_2(fl_ren[2]),
    .fl_read_data_0(fl_data[0]), .fl_read_data_1(fl_data[1]), .fl_read_data_2(fl_data[2]),
    .fl_read_valid_0(fl_rv[0]), .fl_read_valid_1(fl_rv[1]), .fl_read_valid_2(fl_rv[2]),
    .fl_count(fl_count),
    .fl_write_en_0(fl_wen[0]), .fl_write_en_1(fl_wen[1]), .fl_write_en_2(fl_wen[2]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_slot_valid_0(o_sv[0]), .out_slot_valid_1(o_sv[1]), .out_slot_valid_2(o_sv[2]),
    .out_rs1_tag_0(o_rs1[0]), .out_rs1_tag_1(o_rs1[1]), .out_rs1_tag_2(o_rs1[2]),
    .out_rs2_tag_0(o_rs2[0]), .out_rs2_tag_1(o_rs2[1]), .out_rs2_tag_2(o_rs2[2]),
    .out_rd_tag_0(o_rd[0]), .out_rd_tag_1(o_rd[1]), .out_rd_tag_2(o_rd[2]),
    .out_old_tag_0(o_old[0]), .out_old_tag_1(o_old[1]), .out_old_tag_2(o_old[2]),
    .commit_en_0(c_en[0]), .commit_en_1(c_en[1]), .commit_en_2(c_en[2]),
    .commit_rd_0(c_rd[0]), .commit_rd_1(c_rd[1]), .commit_rd_2(c_rd[2]),
    .commit_tag_0(c_tag[0]), .commit_tag_1(c_tag[1]), .commit_tag_2(c_tag[2]),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic v, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic w, input logic [5:0] t);
    slot_valid[k] = v;
    rs1[k]        = a;
    rs2[k]        = b;
    rd[k]         = d;
    rd_write[k]   = w;
    fl_data[k]    = t;
  endtask

  task automatic clear_slots();
    for (int k = 0; k < 3; k++) set_slot(k, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; fl_count = '0;
    clear_slots();
    for (int k = 0; k < 3; k++) begin
      fl_rv[k] = 1'b1; c_en[k] = 1'b0; c_rd[k] = '0; c_tag[k] = '0;
    end

    // Reset: strobes stay low even with a ready group and a commit presented
    in_valid = 1'b1; fl_count = 6'd3;
    set_slot(0, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 6'd32);
    c_en[0] = 1'b1; c_rd[0] = 5'd5; c_tag[0] = 6'd9;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_tag0", o_rd[0], 0);
    check("rst_rs1_tag0", o_rs1[0], 0);
    check("rst_slot_valid0", o_sv[0], 0);
    check("rst_fl_read_en0", fl_ren[0], 0);
    check("rst_fl_write_en0", fl_wen[0], 0);
    in_valid = 1'b0; c_en[0] = 1'b0; clear_slots();
    #2 rst_n = 1'b1;
    tick();

    // Basic group, identity map, 1-cycle latency
    set_slot(0, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 6'd32);
    set_slot(1, 1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 6'd33);
    set_slot(2, 1'b1, 5'd8, 5'd9, 5'd7, 1'b1, 6'd34);
    in_valid = 1'b1; fl_count = 6'd3;
    #1;
    check("g1_in_ready", in_ready, 1);
    check("g1_fl_read_en2", fl_ren[2], 1);
    check("g1_not_yet_valid", out_valid, 0);
    tick();
    check("g1_out_valid", out_valid, 1);
    check("g1_rs1_0", o_rs1[0], 1);
    check("g1_rs2_0", o_rs2[0], 2);
    check("g1_rs1_1", o_rs1[1], 3);
    check("g1_rd_0", o_rd[0], 32);
    check("g1_rd_1", o_rd[1], 33);
    check("g1_rd_2", o_rd[2], 34);
    check("g1_old_0", o_old[0], 5);
    check("g1_old_1", o_old[1], 6);
    check("g1_old_2", o_old[2], 7);
    check("g1_slot_valid0", o_sv[0], 1);
    in_valid = 1'b0;
    tick();
    check("g1_drain", out_valid, 0);

    // Intra-group dependence on rd=3
    set_slot(0, 1'b1, 5'd5, 5'd6, 5'd3, 1'b1, 6'd35);
    set_slot(1, 1'b1, 5'd3, 5'd7, 5'd10, 1'b1, 6'd36);
    set_slot(2, 1'b1, 5'd6, 5'd3, 5'd3, 1'b1, 6'd37);
    in_valid = 1'b1;
    tick();
    check("g2_rs1_0", o_rs1[0], 32);
    check("g2_rs2_0", o_rs2[0], 33);
    check("g2_old_0", o_old[0], 3);
    check("g2_rs1_1_bypass", o_rs1[1], 35);
    check("g2_rs2_1", o_rs2[1], 34);
    check("g2_rs1_2", o_rs1[2], 33);
    check("g2_rs2_2_bypass", o_rs2[2], 35);
    check("g2_old_2_bypass", o_old[2], 35);
    check("g2_rd_2", o_rd[2], 37);

    // Free list short, then sufficient; back-to-back with prior group
    set_slot(0, 1'b1, 5'd3, 5'd10, 5'd11, 1'b1, 6'd38);
    set_slot(1, 1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 6'd39);
    set_slot(2, 1'b1, 5'd0, 5'd12, 5'd13, 1'b1, 6'd42);
    fl_count = 6'd2;
    #1;
    check("fl_short_in_ready", in_ready, 0);
    check("fl_short_read_en0", fl_ren[0], 0);
    tick();
    check("fl_short_drain", out_valid, 0);
    check("fl_short_hold_rd2", o_rd[2], 37);
    fl_count = 6'd3;
    #1;
    check("fl_ok_in_ready", in_ready, 1);
    check("fl_ok_read_en2", fl_ren[2], 1);
    tick();
    check("g3_rs1_0_srat3", o_rs1[0], 37);
    check("g3_rs2_0_srat10", o_rs2[0], 36);
    check("g3_rs1_1_bypass", o_rs1[1], 38);
    check("g3_rs2_1_x0", o_rs2[1], 0);
    check("g3_rs2_2_bypass", o_rs2[2], 39);
    check("g3_old_2", o_old[2], 13);
    check("g3_rd_2", o_rd[2], 42);

    // Backpressure for 4 cycles
    out_ready = 1'b0;
    clear_slots();
    set_slot(0, 1'b1, 5'd13, 5'd0, 5'd14, 1'b1, 6'd43);
    set_slot(1, 1'b0, 5'd0, 5'd0, 5'd15, 1'b1, 6'd0);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_read_en0", fl_ren[0], 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_rd_0_stable", o_rd[0], 38);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_invalid_slot_read_en1", fl_ren[1], 0);
    tick();
    check("g4_rs1_0", o_rs1[0], 42);
    check("g4_rd_0", o_rd[0], 43);
    check("g4_old_0", o_old[0], 14);
    check("g4_slot_valid1", o_sv[1], 0);
    check("g4_rd_1", o_rd[1], 0);

    // Commit rd=5 -> 40, then speculative rename rd=5 -> 41, then flush
    in_valid = 1'b0; clear_slots();
    c_en[0] = 1'b1; c_rd[0] = 5'd5; c_tag[0] = 6'd40;
    #1;
    check("commit_write_en0", fl_wen[0], 1);
    check("commit_write_en1_idle", fl_wen[1], 0);
    tick();
    c_en[0] = 1'b0;
    set_slot(0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 6'd41);
    in_valid = 1'b1;
    #1;
    check("g5_in_ready", in_ready, 1);
    tick();
    check("g5_rs1_0", o_rs1[0], 32);
    check("g5_old_0", o_old[0], 32);
    check("g5_rd_0", o_rd[0], 41);
    flush = 1'b1;
    set_slot(0, 1'b1, 5'd5, 5'd0, 5'd20, 1'b1, 6'd44);
    c_en[1] = 1'b1; c_rd[1] = 5'd3; c_tag[1] = 6'd45;
    #1;
    check("flush_in_ready", in_ready, 0);
    check("flush_read_en0", fl_ren[0], 0);
    check("flush_commit_write_en1", fl_wen[1], 1);
    tick();
    check("flush_out_valid", out_valid, 0);
    check("flush_hold_rd0", o_rd[0], 41);
    flush = 1'b0; c_en[1] = 1'b0;
    set_slot(0, 1'b1, 5'd5, 5'd3, 5'd20, 1'b0, 6'd0);
    #1;
    check("post_flush_no_alloc", fl_ren[0], 0);
    tick();
    check("post_flush_rs1_5", o_rs1[0], 40);
    check("post_flush_rs2_3_same_cycle_commit", o_rs2[0], 45);
    check("post_flush_rd_0", o_rd[0], 0);
    check("post_flush_old_0", o_old[0], 20);

    // x0 handling with empty free list
    set_slot(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0);
    set_slot(1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd0);
    fl_count = 6'd0;
    #1;
    check("x0_in_ready", in_ready, 1);
    check("x0_read_en0", fl_ren[0], 0);
    check("x0_read_en1", fl_ren[1], 0);
    tick();
    check("x0_out_valid", out_valid, 1);
    check("x0_rs1_0", o_rs1[0], 0);
    check("x0_rs2_0", o_rs2[0], 0);
    check("x0_rd_0", o_rd[0], 0);
    check("x0_old_0", o_old[0], 0);
    check("x0_rd_1", o_rd[1], 0);
    check("x0_slot_valid1", o_sv[1], 1);

    // Asynchronous reset mid-operation restores identity
    in_valid = 1'b0; clear_slots();
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    set_slot(0, 1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 6'd50);
    fl_count = 6'd3; in_valid = 1'b1;
    tick();
    check("after_rst_rs1_5", o_rs1[0], 5);
    check("after_rst_rs2_3", o_rs2[0], 3);
    check("after_rst_old_6", o_old[0], 6);
    check("after_rst_rd_0", o_rd[0], 50);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
